gray_counter_ud: RTL and testbench
==================================

Name: gray_counter_ud

Overview:
- Parametrised synchronous Gray-code counter. Successor to the team's fixed 4-bit up-only Gray counter.
- Adds:
  - configurable width
  - count enable and up/down direction
  - synchronous load, with the load value taken as either binary or Gray
  - wrap or saturate mode
  - limit and wrap flags
- Gray and binary outputs are always cycle-aligned. They describe the same count value in the same cycle, with no skew between them.
- Intended for pointer and position tracking across the design, e.g. async FIFO pointers and encoder position.

Parameters:
- WIDTH, 4: counter width in bits, >= 2.
- SATURATE, 0: 0 = wrap at the ends of the range; 1 = hold at the end value.
- RESET_VAL, 0: binary count value loaded on reset. Must be < 2^WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable. Advances the count by one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  in  1  synchronous load strobe.
- load_gray  in  1  1 = load_val is Gray-coded; 0 = load_val is binary.
- load_val  in  WIDTH  value to load.
- bin  out  WIDTH  current count, binary.
- gray  out  WIDTH  current count, Gray code. Always equal to bin ^ (bin >> 1).
- at_max  out  1  high when bin == 2^WIDTH-1.
- at_min  out  1  high when bin == 0.
- wrap  out  1  one-cycle pulse: the most recent update was a wrap-around step.

Behaviour:
- Reset and clock: reset is synchronous and active-high; the clock is clk. All outputs are registered and update only on the rising edge of clk.
- On reset:
  - bin = RESET_VAL
  - gray = RESET_VAL ^ (RESET_VAL >> 1)
  - at_max and at_min reflect RESET_VAL
  - wrap = 0
- Priority per cycle: reset > load > en > hold.
- Load:
  - Binary target = load_val when load_gray=0.
  - When load_gray=1, target = Gray-to-binary conversion of load_val: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Load takes effect in one cycle. wrap = 0 on a load cycle.
  - en and up are ignored on a load cycle.
- Count, when en=1 and load=0:
  - Next value = bin+1 if up=1, else bin-1, computed modulo 2^WIDTH.
  - Wrap event: up=1 and bin == max, or up=0 and bin == 0.
  - SATURATE=0: the count wraps (max -> 0 or 0 -> max), and wrap is set to 1 for exactly the following cycle.
  - SATURATE=1: the count holds at the end value, and wrap stays 0.
- Hold, when en=0 and load=0: bin and gray are unchanged, and wrap = 0.
- Output encoding:
  - gray and bin are derived from the same next-state value in the same cycle.
  - Consecutive gray values produced by counting steps differ in exactly one bit. This includes wrap steps.
  - A saturated hold produces zero changed bits.
- Flags:
  - at_max and at_min are registered alongside bin; they are never combinational from the inputs.
- Latency: one cycle from en, load or reset at the input to the updated outputs.
- Boundary cases:
  - Direction reversal (up toggling while en is held high) takes effect on the same cycle's step, with no bubble.
  - load with load_val equal to the current value is a valid load; wrap = 0.
  - reset asserted mid-count or mid-load overrides everything in that cycle.

Test Plan (WIDTH=4 unless stated):
- Reset, then en=1, up=1 for 16 cycles: bin steps 0..15, then wraps to 0. Gray sequence is 0000, 0001, 0011, 0010, …, 1000, then 0000. Every transition changes exactly one bit; wrap pulses once, in the cycle where bin becomes 0.
- Reset, then en=1, up=0: bin goes 0 -> 15 and gray goes 0000 -> 1000. wrap=1 for one cycle and at_max=1.
- SATURATE=1: load binary 14, then count up 3 cycles: bin = 15, 15, 15; wrap stays 0; at_max=1. Then count down 16 cycles: bin ends at 0, at_min=1, wrap never asserts.
- load=1, load_gray=1, load_val=0110: next cycle bin=4 and gray=0110. Then load_gray=0, load_val=5: bin=5 and gray=0111.
- load and en asserted together (up=1, bin=3, load_val=9 binary): bin=9, not 4. reset together with load: bin=RESET_VAL. en=0: outputs hold for 5 cycles.
- WIDTH=8, RESET_VAL=200: after reset, bin=200 and gray=200^100=172. Free-run 300 up-steps: wrap pulses exactly once, and the Gray single-bit-change check passes on every step.

Source files
------------

// File: rtl/gray_counter_ud_if.sv
// Bus bundle for the up/down Gray counter: control and load inputs plus the
// registered count and flag outputs.
interface gray_counter_ud_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic             load_gray;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             at_max;
  logic             at_min;
  logic             wrap;

  modport master (
    output en, up, load, load_gray, load_val,
    input  bin, gray, at_max, at_min, wrap
  );

  modport slave (
    input  en, up, load, load_gray, load_val,
    output bin, gray, at_max, at_min, wrap
  );
endinterface

// File: rtl/gray_counter_ud.sv
// Parametrised up/down Gray-code counter with synchronous load (binary or
// Gray), wrap or saturate mode, end-of-range flags and a wrap pulse.
// Binary and Gray outputs come from the same registered next value, so they
// always describe the same count in the same cycle.
module gray_counter_ud #(
  parameter int WIDTH     = 4,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  gray_counter_ud_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Returns {wrap_event, next_value}. In saturate mode an end-of-range step
  // holds the value and reports no wrap.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] b,
                                                input logic             dir);
    logic             at_end;
    logic [WIDTH-1:0] n;
    at_end = dir ? (b == MAX_VAL) : (b == '0);
    n      = dir ? (b + 1'b1) : (b - 1'b1);
    if (at_end && (SATURATE != 0)) begin
      return {1'b0, b};
    end
    return {at_end, n};
  endfunction

  logic [WIDTH-1:0] bin_p0;
  logic             wrap_p0;
  logic [WIDTH:0]   step_p0;

  logic [WIDTH-1:0] bin_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             at_max_p1;
  logic             at_min_p1;
  logic             wrap_p1;

  // Stage p0: next count selection, load has priority over counting.
  always_comb begin
    bin_p0  = bin_p1;
    wrap_p0 = 1'b0;
    step_p0 = step_count(bin_p1, bus.up);
    if (bus.load) begin
      bin_p0 = bus.load_gray ? gray2bin(bus.load_val) : bus.load_val;
    end else if (bus.en) begin
      bin_p0  = step_p0[WIDTH-1:0];
      wrap_p0 = step_p0[WIDTH];
    end
  end

  // Stage p1: register count, its Gray form and the flags from one next value.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_p1    <= RST_BIN;
      gray_p1   <= bin2gray(RST_BIN);
      at_max_p1 <= (RST_BIN == MAX_VAL);
      at_min_p1 <= (RST_BIN == '0);
      wrap_p1   <= 1'b0;
    end else begin
      bin_p1    <= bin_p0;
      gray_p1   <= bin2gray(bin_p0);
      at_max_p1 <= (bin_p0 == MAX_VAL);
      at_min_p1 <= (bin_p0 == '0);
      wrap_p1   <= wrap_p0;
    end
  end

  assign bus.bin    = bin_p1;
  assign bus.gray   = gray_p1;
  assign bus.at_max = at_max_p1;
  assign bus.at_min = at_min_p1;
  assign bus.wrap   = wrap_p1;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Self-checking bench for gray_counter_ud: three instances (4-bit wrap,
// 4-bit saturate, 8-bit wrap with RESET_VAL=200) checked each cycle against
// an arithmetic reference model, plus hand-computed literal expectations.
module tb_gray_counter_ud;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gray_counter_ud_if #(.WIDTH(4)) i4 ();
  gray_counter_ud_if #(.WIDTH(4)) i4s ();
  gray_counter_ud_if #(.WIDTH(8)) i8 ();

  gray_counter_ud #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0))
    u4 (.clk(clk), .reset(reset), .bus(i4));
  gray_counter_ud #(.WIDTH(4), .SATURATE(1), .RESET_VAL(0))
    u4s (.clk(clk), .reset(reset), .bus(i4s));
  gray_counter_ud #(.WIDTH(8), .SATURATE(0), .RESET_VAL(200))
    u8 (.clk(clk), .reset(reset), .bus(i8));

  int total = 0;
  int bad = 0;

  // Model configuration and state, one slot per instance.
  int cfg_w[3]  = '{4, 4, 8};
  int cfg_s[3]  = '{0, 1, 0};
  int cfg_rv[3] = '{0, 0, 200};
  int mb[3];
  int mw[3];
  int old_b[3];
  bit stepped[3];
  bit valid[3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray to binary as the XOR of all right shifts of the code.
  function automatic int g2b(input int g, input int w);
    int b = 0;
    for (int s = 0; s < w; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic model_step(input int k, input bit r, input bit ld, input bit lg,
                            input int lv, input bit e, input bit u);
    int maxv = (1 << cfg_w[k]) - 1;
    old_b[k]   = mb[k];
    stepped[k] = valid[k] && !r && !ld && e;
    if (r) begin
      mb[k] = cfg_rv[k]; mw[k] = 0; valid[k] = 1'b1;
    end else if (ld) begin
      mb[k] = lg ? g2b(lv, cfg_w[k]) : lv; mw[k] = 0;
    end else if (e) begin
      mw[k] = 0;
      if (u) begin
        if (mb[k] < maxv) mb[k] = mb[k] + 1;
        else if (cfg_s[k] == 0) begin mb[k] = 0; mw[k] = 1; end
      end else begin
        if (mb[k] > 0) mb[k] = mb[k] - 1;
        else if (cfg_s[k] == 0) begin mb[k] = maxv; mw[k] = 1; end
      end
    end else begin
      mw[k] = 0;
    end
  endtask

  task automatic check_dut(input int k, input int b, input int g,
                           input bit amax, input bit amin, input bit w);
    int maxv = (1 << cfg_w[k]) - 1;
    if (!valid[k]) return;
    check($sformatf("u%0d.bin", k), b, mb[k]);
    check($sformatf("u%0d.gray", k), g, mb[k] ^ (mb[k] >> 1));
    check($sformatf("u%0d.at_max", k), int'(amax), int'(mb[k] == maxv));
    check($sformatf("u%0d.at_min", k), int'(amin), int'(mb[k] == 0));
    check($sformatf("u%0d.wrap", k), int'(w), mw[k]);
    if (stepped[k])
      check($sformatf("u%0d.gray_bits_changed", k),
            $countones(g ^ (old_b[k] ^ (old_b[k] >> 1))),
            int'(mb[k] != old_b[k]));
  endtask

  // Compare process: advance the model on each rising edge from the inputs
  // in force, then check all three instances shortly after the edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step(0, reset, i4.load, i4.load_gray, int'(i4.load_val), i4.en, i4.up);
      model_step(1, reset, i4s.load, i4s.load_gray, int'(i4s.load_val), i4s.en, i4s.up);
      model_step(2, reset, i8.load, i8.load_gray, int'(i8.load_val), i8.en, i8.up);
      #1;
      check_dut(0, int'(i4.bin), int'(i4.gray), i4.at_max, i4.at_min, i4.wrap);
      check_dut(1, int'(i4s.bin), int'(i4s.gray), i4s.at_max, i4s.at_min, i4s.wrap);
      check_dut(2, int'(i8.bin), int'(i8.gray), i8.at_max, i8.at_min, i8.wrap);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_all();
    i4.en = 0;  i4.up = 0;  i4.load = 0;  i4.load_gray = 0;  i4.load_val = '0;
    i4s.en = 0; i4s.up = 0; i4s.load = 0; i4s.load_gray = 0; i4s.load_val = '0;
    i8.en = 0;  i8.up = 0;  i8.load = 0;  i8.load_gray = 0;  i8.load_val = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  int wraps;

  initial begin
    idle_all();
    reset = 1'b1;
    tick(2);
    // Reset values, pinned by hand.
    check("rst_u8_bin", int'(i8.bin), 200);
    check("rst_u8_gray", int'(i8.gray), 172);
    check("rst_u4_at_min", int'(i4.at_min), 1);
    check("rst_u4_wrap", int'(i4.wrap), 0);
    reset = 1'b0;

    // Count up through the full 4-bit range and wrap once.
    i4.en = 1; i4.up = 1;
    wraps = 0;
    tick(8);
    check("up8_gray", int'(i4.gray), 4'b1100);
    for (int i = 0; i < 8; i++) begin
      if (i4.wrap) wraps++;
      tick(1);
    end
    check("up16_bin", int'(i4.bin), 0);
    check("up16_wrap", int'(i4.wrap), 1);
    check("up16_wraps_before", wraps, 0);
    i4.en = 0;

    // Down from zero wraps to max.
    do_reset();
    i4.en = 1; i4.up = 0;
    tick(1);
    check("dn_bin", int'(i4.bin), 15);
    check("dn_gray", int'(i4.gray), 4'b1000);
    check("dn_wrap", int'(i4.wrap), 1);
    check("dn_at_max", int'(i4.at_max), 1);
    i4.en = 0;

    // Saturate mode: load 14, push up past max, then down past min.
    i4s.load = 1; i4s.load_val = 4'd14;
    tick(1);
    i4s.load = 0; i4s.en = 1; i4s.up = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("sat_up_bin", int'(i4s.bin), 15);
      check("sat_up_wrap", int'(i4s.wrap), 0);
    end
    i4s.up = 0;
    tick(16);
    check("sat_dn_bin", int'(i4s.bin), 0);
    check("sat_dn_at_min", int'(i4s.at_min), 1);
    i4s.en = 0;

    // Gray load then binary load.
    i4.load = 1; i4.load_gray = 1; i4.load_val = 4'b0110;
    tick(1);
    check("ldg_bin", int'(i4.bin), 4);
    check("ldg_gray", int'(i4.gray), 4'b0110);
    i4.load_gray = 0; i4.load_val = 4'd5;
    tick(1);
    check("ldb_bin", int'(i4.bin), 5);
    check("ldb_gray", int'(i4.gray), 4'b0111);

    // Load beats enable; reset beats load; hold when idle.
    i4.load_val = 4'd3;
    tick(1);
    i4.en = 1; i4.up = 1; i4.load_val = 4'd9;
    tick(1);
    check("ld_over_en", int'(i4.bin), 9);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_over_ld", int'(i4.bin), 0);
    i4.load_val = 4'd7; i4.en = 0;
    tick(1);
    i4.load = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_bin", int'(i4.bin), 7);
    end

    // 8-bit free run of 300 up-steps from 200: exactly one wrap.
    do_reset();
    i8.en = 1; i8.up = 1;
    wraps = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (i8.wrap) wraps++;
    end
    check("u8_wraps", wraps, 1);
    check("u8_final_bin", int'(i8.bin), (200 + 300) % 256);
    idle_all();

    // Randomized traffic on all instances, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(63) == 0);
      i4.load       = ($urandom_range(7) == 0);
      i4.load_gray  = 1'($urandom);
      i4.load_val   = 4'($urandom);
      i4.en         = ($urandom_range(3) != 0);
      i4.up         = 1'($urandom);
      i4s.load      = ($urandom_range(15) == 0);
      i4s.load_gray = 1'($urandom);
      i4s.load_val  = 4'($urandom);
      i4s.en        = ($urandom_range(3) != 0);
      i4s.up        = ($urandom_range(9) < 6);
      i8.load       = ($urandom_range(31) == 0);
      i8.load_gray  = 1'($urandom);
      i8.load_val   = 8'($urandom);
      i8.en         = ($urandom_range(3) != 0);
      i8.up         = ($urandom_range(9) < 3);
      tick(1);
    end
    reset = 1'b0;
    idle_all();
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
